// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encodings, signature width
// and the address-width helper used to size cfg_addr.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int SIG_W = 16;

    // ceil(log2(n)) but never below 1, so a single-function build still has an address bit
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_lut.sv
// Truth-table storage: N_OUT columns of 2**N_IN bits, one write port, parallel read at idx.
// Read is purely combinational from registers; writes land on the next rising edge.
module truth_table_sweeper_lut
    import truth_table_sweeper_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int N_OUT = 2,
    localparam int D     = 1 << N_IN,
    localparam int AW    = clog2_min1(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [D-1:0]     data,
    input  logic [N_IN-1:0]  idx,
    output logic [N_OUT-1:0] s
);

    logic [D-1:0] tbl [N_OUT];

    // Addresses beyond N_OUT-1 match no column and are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) tbl[k] <= '0;
        end else if (we) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (addr == AW'(k)) tbl[k] <= data;
            end
        end
    end

    always_comb begin
        s = '0;
        for (int k = 0; k < N_OUT; k++) s[k] = tbl[k][idx];
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of N_OUT programmable boolean functions under valid/ready.
// One vector per cycle with vec_ready high; vectors hold while stalled. Optional signature: TT_SIG_EN.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter  int N_IN  = 2,
    parameter  int N_OUT = 2,
    localparam int D     = 1 << N_IN,
    localparam int AW    = clog2_min1(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [D-1:0]     cfg_data,
    input  logic             start,
    input  logic             abort,
    input  logic             vec_ready,
    output logic             vec_valid,
    output logic [N_IN-1:0]  vec_x,
    output logic [N_OUT-1:0] vec_s,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(D - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_OUT-1:0]  lut_s;
    logic              in_idle;
    logic              transfer;
    logic              xfer_ok;

    assign in_idle   = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SWEEP);
    assign vec_valid = busy;
    assign done      = (state_q == ST_DONE);
    assign transfer  = vec_valid & vec_ready;
    // abort cancels a coincident transfer
    assign xfer_ok   = transfer & ~abort;

    assign vec_x = busy ? idx_q : '0;
    assign vec_s = busy ? lut_s : '0;

    // Tables are frozen outside IDLE; a write coinciding with start is used by that sweep
    truth_table_sweeper_lut #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we & in_idle),
        .addr  (cfg_addr),
        .data  (cfg_data),
        .idx   (idx_q),
        .s     (lut_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (transfer) begin
                    if (idx_q == IDX_LAST) state_d = ST_DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef TT_SIG_EN
    logic [SIG_W-1:0] sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= '0;
        end else if (in_idle && start) begin
            sig_q <= '0;
        end else if (xfer_ok) begin
            sig_q <= {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(vec_s);
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [0:0]  cfg_addr;
    logic [3:0]  cfg_data;
    logic        start;
    logic        abort;
    logic        vec_ready;
    logic        vec_valid;
    logic [1:0]  vec_x;
    logic [1:0]  vec_s;
    logic        busy;
    logic        done;
    logic [15:0] sig;

    int checks;
    int failures;

    logic [1:0]  exp_s   [4];
    logic [1:0]  exp_new [4];
    logic [15:0] exp_sig;

    truth_table_sweeper #(.N_IN(2), .N_OUT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .abort     (abort),
        .vec_ready (vec_ready),
        .vec_valid (vec_valid),
        .vec_x     (vec_x),
        .vec_s     (vec_s),
        .busy      (busy),
        .done      (done),
        .sig       (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_col(input logic a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({vec_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {vec_valid, busy, done}); end
        checks++; if (vec_x !== 2'b00) begin failures++; $display("FAIL reset_vec_x got=%b exp=00", vec_x); end
        checks++; if (vec_s !== 2'b00) begin failures++; $display("FAIL reset_vec_s got=%b exp=00", vec_s); end
        checks++; if (sig !== 16'h0000) begin failures++; $display("FAIL reset_sig got=%h exp=0000", sig); end
    endtask

    // Full sweep at vec_ready=1: four back-to-back vectors, one done pulse
    task automatic test_sweep();
        program_col(1'b0, 4'b0011);
        program_col(1'b1, 4'b1110);
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({vec_valid, busy, done} !== 3'b110) begin failures++; $display("FAIL sweep_ctrl[%0d] got=%b exp=110", i, {vec_valid, busy, done}); end
            checks++; if (vec_x !== 2'(i)) begin failures++; $display("FAIL sweep_vec_x[%0d] got=%b exp=%b", i, vec_x, 2'(i)); end
            checks++; if (vec_s !== exp_s[i]) begin failures++; $display("FAIL sweep_vec_s[%0d] got=%b exp=%b", i, vec_s, exp_s[i]); end
            tick();
        end
        checks++; if ({vec_valid, busy, done} !== 3'b001) begin failures++; $display("FAIL sweep_done got=%b exp=001", {vec_valid, busy, done}); end
        checks++; if (vec_x !== 2'b00 || vec_s !== 2'b00) begin failures++; $display("FAIL sweep_idle_zero got=%b/%b exp=00/00", vec_x, vec_s); end
        tick();
        checks++; if ({vec_valid, busy, done} !== 3'b000) begin failures++; $display("FAIL sweep_after_done got=%b exp=000", {vec_valid, busy, done}); end
        checks++; if (sig !== exp_sig) begin failures++; $display("FAIL sweep_sig got=%h exp=%h", sig, exp_sig); end
        vec_ready = 1'b0;
        tick();
        checks++; if (sig !== exp_sig) begin failures++; $display("FAIL sweep_sig_hold got=%h exp=%h", sig, exp_sig); end
    endtask

    task automatic test_backpressure();
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vec_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (vec_valid !== 1'b1 || vec_x !== 2'b01 || vec_s !== 2'b11) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%b/%b exp=1/01/11", c, vec_valid, vec_x, vec_s); end
            tick();
        end
        vec_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (vec_x !== 2'(i) || vec_s !== exp_s[i]) begin failures++; $display("FAIL bp_resume[%0d] got=%b/%b exp=%b/%b", i, vec_x, vec_s, 2'(i), exp_s[i]); end
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done); end
        tick();
        checks++; if (sig !== exp_sig) begin failures++; $display("FAIL bp_sig got=%h exp=%h", sig, exp_sig); end
        vec_ready = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++; if (vec_x !== 2'b10) begin failures++; $display("FAIL abort_pre_idx got=%b exp=10", vec_x); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({vec_valid, busy, done} !== 3'b000 || vec_x !== 2'b00) begin failures++; $display("FAIL abort_idle[%0d] got=%b/%b exp=000/00", c, {vec_valid, busy, done}, vec_x); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vec_valid !== 1'b1 || vec_x !== 2'(i) || vec_s !== exp_s[i]) begin failures++; $display("FAIL abort_restart[%0d] got=%b/%b/%b exp=1/%b/%b", i, vec_valid, vec_x, vec_s, 2'(i), exp_s[i]); end
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL abort_restart_done got=%b exp=1", done); end
        tick();
        vec_ready = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (vec_x !== 2'b01) begin failures++; $display("FAIL rst_pre_idx got=%b exp=01", vec_x); end
        reset = 1'b1;
        #1;
        checks++; if ({vec_valid, busy, done} !== 3'b000 || vec_x !== 2'b00 || vec_s !== 2'b00) begin failures++; $display("FAIL rst_async got=%b/%b/%b exp=000/00/00", {vec_valid, busy, done}, vec_x, vec_s); end
        checks++; if (sig !== 16'h0000) begin failures++; $display("FAIL rst_async_sig got=%h exp=0000", sig); end
        tick();
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vec_x !== 2'(i) || vec_s !== 2'b00) begin failures++; $display("FAIL rst_cleared[%0d] got=%b/%b exp=%b/00", i, vec_x, vec_s, 2'(i)); end
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_cleared_done got=%b exp=1", done); end
        tick();
        checks++; if (sig !== 16'h0000) begin failures++; $display("FAIL rst_cleared_sig got=%h exp=0000", sig); end
        vec_ready = 1'b0;
    endtask

    // cfg_we and start during SWEEP must not disturb the sweep or the table
    task automatic test_ignore_in_sweep();
        int dones;
        program_col(1'b0, 4'b0011);
        program_col(1'b1, 4'b1110);
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cfg_we = 1'b1;
        cfg_addr = 1'b0;
        cfg_data = 4'b1111;
        start = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (vec_x !== 2'(i) || vec_s !== exp_s[i]) begin failures++; $display("FAIL ign_sweep[%0d] got=%b/%b exp=%b/%b", i, vec_x, vec_s, 2'(i), exp_s[i]); end
            tick();
        end
        cfg_we = 1'b0;
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_restart got=%b exp=0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vec_s !== exp_s[i]) begin failures++; $display("FAIL ign_table_kept[%0d] got=%b exp=%b", i, vec_s, exp_s[i]); end
            tick();
        end
        tick();
        vec_ready = 1'b0;
    endtask

    // Write and start in the same IDLE cycle: sweep sees the new column
    task automatic test_cfg_with_start();
        cfg_we = 1'b1;
        cfg_addr = 1'b0;
        cfg_data = 4'b1111;
        start = 1'b1;
        vec_ready = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vec_s !== exp_new[i]) begin failures++; $display("FAIL cfg_start[%0d] got=%b exp=%b", i, vec_s, exp_new[i]); end
            tick();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL cfg_start_done got=%b exp=1", done); end
        tick();
        vec_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        // vec_s = {x|y, ~x} for x y = 00,01,10,11
        exp_s[0] = 2'b01; exp_s[1] = 2'b11; exp_s[2] = 2'b10; exp_s[3] = 2'b10;
        exp_new[0] = 2'b01; exp_new[1] = 2'b11; exp_new[2] = 2'b11; exp_new[3] = 2'b11;
`ifdef TT_SIG_EN
        exp_sig = 16'h0002;
`else
        exp_sig = 16'h0000;
`endif
        reset = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = 1'b0;
        cfg_data = 4'b0000;
        start = 1'b0;
        abort = 1'b0;
        vec_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        test_sweep();
        test_backpressure();
        test_abort();
        test_reset_mid_sweep();
        test_ignore_in_sweep();
        test_cfg_with_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
